// File: rtl/ifmap_dispatch_engine.sv
// ifmap_dispatch_engine
//   Holds NUM_TS binary spike maps of MAP_SIZE x MAP_SIZE in flops. On start it
//   sweeps every convolution window (ts, r, c) and, for each window, sends one
//   packet per (filter row i, PE column j) to the PE address table. It then
//   waits for one acknowledge before moving on to the next window.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   ld_valid/ld_ready       map load beat handshake (IDLE only)
//   ld_ts, ld_addr, ld_data target map, linear address row*MAP_SIZE+col, spike bit
//   start                   single-cycle pulse, honoured only in IDLE
//   busy                    high from start acceptance through the done cycle
//   pkt_valid/pkt_ready     outgoing NoC packet handshake, pkt_data = packet
//   ack_valid/ack_ready     window-complete packet handshake, ack_data ignored
//   done                    one-cycle pulse after the final acknowledge
//
// Build option
//   ZERO_SKIP_EN  when defined, an (i,j) index whose payload is all zero is
//                 skipped in one cycle without a bus transfer.
`timescale 1ns/1ps

module ifmap_dispatch_engine #(
    parameter int                            MAP_SIZE    = 32,
    parameter int                            K           = 5,
    parameter int                            NUM_TS      = 2,
    parameter int                            NUM_PE_COLS = 2,
    parameter int                            COL_STEP    = 3,
    parameter int                            ADDR_W      = 4,
    parameter int                            WIDTH       = 35,
    parameter logic [ADDR_W-1:0]             SRC_ADDR    = 4'b0000,
    parameter logic [K*NUM_PE_COLS*ADDR_W-1:0] PE_ADDR   = 40'hEA62D951C8
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          ld_valid,
    output logic                                          ld_ready,
    input  logic [((NUM_TS > 1) ? $clog2(NUM_TS) : 1)-1:0] ld_ts,
    input  logic [$clog2(MAP_SIZE*MAP_SIZE)-1:0]          ld_addr,
    input  logic                                          ld_data,
    input  logic                                          start,
    output logic                                          busy,
    output logic                                          pkt_valid,
    input  logic                                          pkt_ready,
    output logic [WIDTH-1:0]                              pkt_data,
    input  logic                                          ack_valid,
    output logic                                          ack_ready,
    input  logic [WIDTH-1:0]                              ack_data,
    output logic                                          done
);

    localparam int TS_W     = (NUM_TS > 1) ? $clog2(NUM_TS) : 1;
    localparam int C_W      = $clog2(MAP_SIZE);
    localparam int I_W      = (K > 1) ? $clog2(K) : 1;
    localparam int J_W      = (NUM_PE_COLS > 1) ? $clog2(NUM_PE_COLS) : 1;
    // Wide enough for the furthest column a window can touch, past the map edge.
    localparam int COLX_W   = $clog2(MAP_SIZE + NUM_PE_COLS*COL_STEP + K) + 1;
    localparam int LAST_POS = MAP_SIZE - K;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_ACK, S_DONE} state_e;

    state_e              state_q;
    logic [TS_W-1:0]     ts_q;
    logic [C_W-1:0]      r_q, c_q;
    logic [I_W-1:0]      i_q;
    logic [J_W-1:0]      j_q;
    logic                ld_ready_q, busy_q, ack_ready_q, done_q;
    logic [MAP_SIZE-1:0] mem_q [NUM_TS][MAP_SIZE];

    logic                ld_wr_en;
    logic [C_W-1:0]      ld_row, ld_col;
    logic [C_W-1:0]      row_x;
    logic [COLX_W-1:0]   col_x;
    logic [K-1:0]        payload;
    logic [ADDR_W-1:0]   pe_dest;
    logic [WIDTH-1:0]    pkt_word;
    logic                skip_idx, last_idx;
    int                  cur_idx;
    int                  c_step;
    logic                ack_data_unused;

    assign ack_data_unused = ^ack_data;

    // ---------------- map load ----------------
    always_comb begin
        ld_row   = C_W'(int'(ld_addr) / MAP_SIZE);
        ld_col   = C_W'(int'(ld_addr) % MAP_SIZE);
        // Out-of-range beats are still accepted but never written.
        ld_wr_en = (state_q == S_IDLE) && ld_valid && ld_ready_q &&
                   (int'(ld_ts) < NUM_TS) && (int'(ld_addr) < MAP_SIZE*MAP_SIZE);
    end

    // NOTE: the map is reset explicitly because a reset must leave it all-zero;
    // a plain RAM without reset could not guarantee that.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_TS; t++)
                for (int y = 0; y < MAP_SIZE; y++)
                    mem_q[t][y] <= '0;
        end else if (ld_wr_en) begin
            mem_q[ld_ts][ld_row][ld_col] <= ld_data;
        end
    end

    // ---------------- packet formation ----------------
    // NOTE: every variable written in an always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        payload = '0;
        col_x   = '0;
        row_x   = r_q + C_W'(i_q);
        for (int b = 0; b < K; b++) begin
            col_x = COLX_W'(c_q) + COLX_W'(j_q) * COLX_W'(COL_STEP) + COLX_W'(b);
            // Columns past the right edge read as zero.
            if (col_x < COLX_W'(MAP_SIZE))
                payload[K-1-b] = mem_q[ts_q][row_x][col_x[C_W-1:0]];
        end
    end

    assign cur_idx = int'(i_q) * NUM_PE_COLS + int'(j_q);

    always_comb begin
        pe_dest = '0;
        for (int n = 0; n < K*NUM_PE_COLS; n++)
            if (n == cur_idx)
                pe_dest = PE_ADDR[n*ADDR_W +: ADDR_W];
    end

    always_comb begin
        pkt_word                             = '0;
        pkt_word[K-1:0]                      = payload;
        pkt_word[WIDTH-1 -: ADDR_W]          = SRC_ADDR;
        pkt_word[WIDTH-ADDR_W-1 -: ADDR_W]   = pe_dest;
        pkt_word[WIDTH-2*ADDR_W-1 -: 3]      = 3'b001;
    end

`ifdef ZERO_SKIP_EN
    assign skip_idx = (state_q == S_SEND) && (payload == '0);
`else
    assign skip_idx = 1'b0;
`endif

    assign last_idx = (i_q == I_W'(K-1)) && (j_q == J_W'(NUM_PE_COLS-1));
    assign c_step   = int'(c_q) + COL_STEP;

    // ---------------- control FSM ----------------
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ts_q        <= '0;
            r_q         <= '0;
            c_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            ld_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            ack_ready_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ld_ready_q <= 1'b1;
                    if (start) begin
                        state_q    <= S_SEND;
                        ld_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        ts_q       <= '0;
                        r_q        <= '0;
                        c_q        <= '0;
                        i_q        <= '0;
                        j_q        <= '0;
                    end
                end
                S_SEND: begin
                    if (pkt_ready || skip_idx) begin
                        if (last_idx) begin
                            state_q     <= S_WAIT_ACK;
                            ack_ready_q <= 1'b1;
                            i_q         <= '0;
                            j_q         <= '0;
                        end else if (j_q == J_W'(NUM_PE_COLS-1)) begin
                            j_q <= '0;
                            i_q <= i_q + I_W'(1);
                        end else begin
                            j_q <= j_q + J_W'(1);
                        end
                    end
                end
                S_WAIT_ACK: begin
                    if (ack_valid && ack_ready_q) begin
                        ack_ready_q <= 1'b0;
                        if (c_step <= LAST_POS) begin
                            c_q     <= C_W'(c_step);
                            state_q <= S_SEND;
                        end else if (r_q != C_W'(LAST_POS)) begin
                            c_q     <= '0;
                            r_q     <= r_q + C_W'(1);
                            state_q <= S_SEND;
                        end else if (ts_q != TS_W'(NUM_TS-1)) begin
                            c_q     <= '0;
                            r_q     <= '0;
                            ts_q    <= ts_q + TS_W'(1);
                            state_q <= S_SEND;
                        end else begin
                            c_q     <= '0;
                            r_q     <= '0;
                            ts_q    <= '0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_q     <= 1'b0;
                    busy_q     <= 1'b0;
                    ld_ready_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // pkt_data only depends on registered counters and the map, both frozen
    // in SEND, so it is stable while pkt_valid waits for pkt_ready.
    assign ld_ready  = ld_ready_q;
    assign busy      = busy_q;
    assign ack_ready = ack_ready_q;
    assign done      = done_q;
    assign pkt_valid = (state_q == S_SEND) && !skip_idx;
    assign pkt_data  = pkt_valid ? pkt_word : '0;

endmodule

// File: tb/tb_ifmap_dispatch_engine.sv
// Directed bench for ifmap_dispatch_engine at default parameters.
`timescale 1ns/1ps

module tb_ifmap_dispatch_engine;

`ifdef ZERO_SKIP_EN
    localparam bit SKIP_ZERO = 1'b1;
`else
    localparam bit SKIP_ZERO = 1'b0;
`endif
    localparam int WAIT_BUDGET = SKIP_ZERO ? 12 : 0;

    // Destination per idx = i*2+j, written out from the PE address table.
    localparam logic [3:0] DEST_TAB [10] = '{4'h8, 4'hC, 4'h1, 4'h5, 4'h9,
                                             4'hD, 4'h2, 4'h6, 4'hA, 4'hE};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_valid, ld_ready;
    logic [0:0]  ld_ts;
    logic [9:0]  ld_addr;
    logic        ld_data;
    logic        start, busy;
    logic        pkt_valid, pkt_ready;
    logic [34:0] pkt_data;
    logic        ack_valid, ack_ready;
    logic [34:0] ack_data;
    logic        done;

    int n_assert = 0;
    int n_fail   = 0;
    int n_pkts   = 0;
    int n_acks   = 0;
    int n_done   = 0;

    bit mdl [2][32][32];

    ifmap_dispatch_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_ts     (ld_ts),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .start     (start),
        .busy      (busy),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .pkt_data  (pkt_data),
        .ack_valid (ack_valid),
        .ack_ready (ack_ready),
        .ack_data  (ack_data),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Handshake counters, sampled on the active edge.
    always @(posedge clk) begin
        if (pkt_valid && pkt_ready) n_pkts++;
        if (ack_valid && ack_ready) n_acks++;
        if (done) n_done++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [34:0] exp_pkt(input int ts, input int r, input int c,
                                             input int i, input int j);
        logic [4:0] p;
        int col;
        p = '0;
        for (int b = 0; b < 5; b++) begin
            col = c + j*3 + b;
            if (col < 32) p[4-b] = mdl[ts][r+i][col];
        end
        return {4'h0, DEST_TAB[i*2+j], 3'b001, 19'b0, p};
    endfunction

    task automatic load_beat(input int ts, input int row, input int col,
                             input bit d, input bit with_start);
        check("ld_ready_beat", 64'(ld_ready), 64'(1'b1));
        ld_valid = 1'b1;
        ld_ts    = 1'(ts);
        ld_addr  = 10'(row*32 + col);
        ld_data  = d;
        start    = with_start;
        @(negedge clk);
        ld_valid = 1'b0;
        start    = 1'b0;
        mdl[ts][row][col] = d;
    endtask

    // Walks every window in order, checking each packet against the model and
    // returning one ack per window.
    task automatic run_dispatch(input bit specials, input logic [4:0] lit0,
                                input logic [4:0] lit1);
        int w, n, exp_pkts, pkt_base, ack_base, done_base;
        bit ok;
        logic [34:0] e;
        w = 0; exp_pkts = 0;
        pkt_base = n_pkts; ack_base = n_acks; done_base = n_done;
        pkt_ready = 1'b1;
        for (int ts = 0; ts < 2; ts++)
        for (int r = 0; r <= 27; r++)
        for (int c = 0; c <= 27; c += 3) begin
            for (int i = 0; i < 5; i++)
            for (int j = 0; j < 2; j++) begin
                e = exp_pkt(ts, r, c, i, j);
                if (SKIP_ZERO && e[4:0] == 5'b0) continue;
                if (specials && w == 1) ack_valid = 1'b1;
                n = 0;
                while (pkt_valid !== 1'b1 && n < WAIT_BUDGET) begin
                    @(negedge clk); n++;
                end
                check("pkt_valid", 64'(pkt_valid), 64'(1'b1));
                check("pkt_data", 64'(pkt_data), 64'(e));
                if (w == 0 && i == 0 && j == 0)
                    check("first_pkt", 64'(pkt_data), 64'({4'h0, 4'h8, 3'b001, 19'b0, lit0}));
                if (w == 0 && i == 0 && j == 1)
                    check("second_pkt", 64'(pkt_data), 64'({4'h0, 4'hC, 3'b001, 19'b0, lit1}));
                if (specials && ts == 1 && r == 27 && c == 27) begin
                    if (i == 0 && j == 0)
                        check("edge_idx0", 64'(pkt_data), 64'({4'h0, 4'h8, 3'b001, 19'b0, 5'b00001}));
                    if (i == 0 && j == 1)
                        check("edge_idx1", 64'(pkt_data), 64'({4'h0, 4'hC, 3'b001, 19'b0, 5'b01000}));
                    if (i == 4 && j == 1)
                        check("edge_idx9", 64'(pkt_data), 64'({4'h0, 4'hE, 3'b001, 19'b0, 5'b01000}));
                end
                if (specials && w == 1)
                    check("ack_ready_in_send", 64'(ack_ready), 64'(1'b0));
                if (specials && w == 0 && i == 2 && j == 0) begin
                    pkt_ready = 1'b0;
                    ok = 1'b1;
                    repeat (5) begin
                        @(negedge clk);
                        if (pkt_valid !== 1'b1 || pkt_data !== e) ok = 1'b0;
                    end
                    check("stall_hold", 64'(ok), 64'(1'b1));
                    check("stall_no_accept", 64'(n_pkts - pkt_base), 64'(exp_pkts));
                    pkt_ready = 1'b1;
                end
                if (specials && w == 2 && i == 0 && j == 0) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                exp_pkts++;
            end
            ack_valid = 1'b0;
            n = 0;
            while (ack_ready !== 1'b1 && n < WAIT_BUDGET) begin
                @(negedge clk); n++;
            end
            check("ack_ready", 64'(ack_ready), 64'(1'b1));
            if (specials && w == 0) begin
                check("win0_pkt_count", 64'(n_pkts - pkt_base), 64'(exp_pkts));
                ok = 1'b1;
                repeat (20) begin
                    @(negedge clk);
                    if (pkt_valid !== 1'b0 || ack_ready !== 1'b1) ok = 1'b0;
                end
                check("ack_withhold_quiet", 64'(ok), 64'(1'b1));
            end
            ack_valid = 1'b1;
            @(negedge clk);
            ack_valid = 1'b0;
            w++;
        end
        check("done_pulse", 64'(done), 64'(1'b1));
        check("busy_in_done", 64'(busy), 64'(1'b1));
        check("no_pkt_in_done", 64'(pkt_valid), 64'(1'b0));
        @(negedge clk);
        check("done_cleared", 64'(done), 64'(1'b0));
        check("busy_cleared", 64'(busy), 64'(1'b0));
        check("ld_ready_after_done", 64'(ld_ready), 64'(1'b1));
        check("total_pkts", 64'(n_pkts - pkt_base), 64'(exp_pkts));
        check("total_acks", 64'(n_acks - ack_base), 64'(w));
        check("done_cycles", 64'(n_done - done_base), 64'(1));
    endtask

    initial begin
        rst_n = 1'b0; ld_valid = 1'b0; ld_ts = '0; ld_addr = '0; ld_data = 1'b0;
        start = 1'b0; pkt_ready = 1'b0; ack_valid = 1'b0; ack_data = '0;
        mdl = '{default: 1'b0};

        // Reset values.
        #12;
        check("rst_ld_ready", 64'(ld_ready), 64'(1'b0));
        check("rst_busy", 64'(busy), 64'(1'b0));
        check("rst_pkt_valid", 64'(pkt_valid), 64'(1'b0));
        check("rst_pkt_data", 64'(pkt_data), 64'(0));
        check("rst_ack_ready", 64'(ack_ready), 64'(1'b0));
        check("rst_done", 64'(done), 64'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ld_ready", 64'(ld_ready), 64'(1'b1));
        check("idle_busy", 64'(busy), 64'(1'b0));

        // Map: ts1 bottom-right corner bits, ts0 row0 cols0..7 with the last
        // beat coinciding with start.
        load_beat(1, 27, 31, 1'b1, 1'b0);
        load_beat(1, 31, 31, 1'b1, 1'b0);
        for (int col = 0; col < 7; col++) load_beat(0, 0, col, 1'b1, 1'b0);
        load_beat(0, 0, 7, 1'b1, 1'b1);
        check("busy_after_start", 64'(busy), 64'(1'b1));
        check("ld_ready_in_send", 64'(ld_ready), 64'(1'b0));
        run_dispatch(1'b1, 5'b11111, 5'b11111);

        // Reset in the middle of SEND.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_sending", 64'(pkt_valid), 64'(1'b1));
        #2 rst_n = 1'b0;
        #1;
        check("abort_pkt_valid", 64'(pkt_valid), 64'(1'b0));
        check("abort_pkt_data", 64'(pkt_data), 64'(0));
        check("abort_busy", 64'(busy), 64'(1'b0));
        check("abort_ld_ready", 64'(ld_ready), 64'(1'b0));
        check("abort_ack_ready", 64'(ack_ready), 64'(1'b0));
        check("abort_done", 64'(done), 64'(1'b0));
        mdl = '{default: 1'b0};
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reidle_ld_ready", 64'(ld_ready), 64'(1'b1));

        // Memory was lost: only cols 0..2 of ts0 row0 are set now.
        for (int col = 0; col < 3; col++) load_beat(0, 0, col, 1'b1, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_dispatch(1'b0, 5'b11100, 5'b00000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
